mainmem_responder: RTL and testbench

- Main-memory responder on the far side of the data-cache refill/writeback interface.
- Accepts one line request at a time from the cache miss/dirty-eviction logic.
- After a fixed access latency, a read request streams a line of words back; a write request absorbs a line of words into storage.
- Provides the backing store the memory stage depends on during cache misses.

---
 rtl/mainmem_responder.sv | 169 ++++++++++++++++
 tb/tb_mainmem_responder.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/mainmem_responder.sv
// Main-memory responder for the data-cache refill/writeback port.
// Accepts one line request at a time. After LATENCY idle cycles it either
// streams a line of words back (read) or absorbs a line of words (write).
// Optional build macro MAINMEM_CWF_EN: read bursts start at the requested
// word (critical-word-first) and wrap within the line; otherwise every
// read burst starts at the line base.
module mainmem_responder #(
    parameter int WORDS      = 4,
    parameter int LATENCY    = 8,
    parameter int DEPTH_LOG2 = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        reqvalid,
    output logic        reqready,
    input  logic        reqwrite,
    input  logic [31:0] reqaddr,
    input  logic        wvalid,
    input  logic [31:0] wdata,
    output logic        wready,
    output logic        rvalid,
    output logic [31:0] rdata,
    output logic        rlast,
    output logic        done,
    output logic        busy
);

    localparam int OW     = $clog2(WORDS);
    localparam int LINE_W = DEPTH_LOG2 - OW;
    localparam int DEPTH  = 1 << DEPTH_LOG2;
    localparam int LW     = (LATENCY > 0) ? $clog2(LATENCY + 1) : 1;

    localparam logic [OW-1:0] LAST_BEAT = OW'(WORDS - 1);
    localparam logic [LW-1:0] LAT_LOAD  = LW'(LATENCY);

    typedef enum logic [2:0] {IDLE, WAIT, RBURST, WBURST, DONE} state_t;

    state_t                 state;
    state_t                 state_next;
    logic [LINE_W-1:0]      line;
    logic                   is_write;
    logic [OW-1:0]          beat;
    logic [LW-1:0]          lat_cnt;
    logic [OW-1:0]          rd_off;
    logic [DEPTH_LOG2-1:0]  rd_idx;
    logic [DEPTH_LOG2-1:0]  wr_idx;
    logic                   accept;
    logic                   wbeat;
    logic                   unused_addr;
    logic [31:0]            mem [DEPTH];

    assign accept = reqready && reqvalid;
    assign wbeat  = wready && wvalid;

`ifdef MAINMEM_CWF_EN
    logic [OW-1:0] offset;

    // Capture the requested word offset; the read burst wraps around it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            offset <= '0;
        end else if (accept) begin
            offset <= reqaddr[OW+1:2];
        end
    end

    assign rd_off      = beat + offset;
    assign unused_addr = ^{reqaddr[31:DEPTH_LOG2+2], reqaddr[1:0]};
`else
    assign rd_off      = beat;
    assign unused_addr = ^{reqaddr[31:DEPTH_LOG2+2], reqaddr[OW+1:0]};
`endif

    // Beat offsets are OW bits wide, so addresses never carry out of the line.
    assign rd_idx = {line, rd_off};
    assign wr_idx = {line, beat};

    // Read data is only driven during a read beat; zero otherwise.
    assign rdata = rvalid ? mem[rd_idx] : '0;

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and output decode.
    always_comb begin
        state_next = state;
        reqready   = 1'b0;
        busy       = 1'b1;
        wready     = 1'b0;
        rvalid     = 1'b0;
        rlast      = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                // Held low while reset is asserted even though state is IDLE.
                reqready = reset;
                if (reqvalid && reset) begin
                    if (LATENCY > 0) begin
                        state_next = WAIT;
                    end else begin
                        state_next = reqwrite ? WBURST : RBURST;
                    end
                end
            end
            WAIT: begin
                if (lat_cnt == LW'(1)) begin
                    state_next = is_write ? WBURST : RBURST;
                end
            end
            RBURST: begin
                rvalid = 1'b1;
                rlast  = (beat == LAST_BEAT);
                if (beat == LAST_BEAT) begin
                    state_next = IDLE;
                end
            end
            WBURST: begin
                wready = 1'b1;
                if (wvalid && (beat == LAST_BEAT)) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Request capture, latency countdown and beat counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            line     <= '0;
            is_write <= 1'b0;
            beat     <= '0;
            lat_cnt  <= '0;
        end else begin
            if (accept) begin
                line     <= reqaddr[DEPTH_LOG2+1:OW+2];
                is_write <= reqwrite;
                beat     <= '0;
                lat_cnt  <= LAT_LOAD;
            end
            if (state == WAIT) begin
                lat_cnt <= lat_cnt - 1'b1;
            end
            // Wraps to zero after the last beat, ready for the next line.
            if (rvalid || wbeat) begin
                beat <= beat + 1'b1;
            end
        end
    end

    // Backing store; deliberately not reset so contents survive a reset.
    always_ff @(posedge clk) begin
        if (wbeat) begin
            mem[wr_idx] <= wdata;
        end
    end

endmodule

// File: tb/tb_mainmem_responder.sv
// Directed bench for mainmem_responder with a read-data scoreboard.
// Honors MAINMEM_CWF_EN when computing expected read order.
module tb_mainmem_responder;

    localparam int WORDS      = 4;
    localparam int LATENCY    = 8;
    localparam int DEPTH_LOG2 = 10;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        reqvalid = 1'b0;
    logic        reqwrite = 1'b0;
    logic [31:0] reqaddr = '0;
    logic        wvalid = 1'b0;
    logic [31:0] wdata = '0;
    logic        reqready, wready, rvalid, rlast, done, busy;
    logic [31:0] rdata;

    int tests = 0;
    int fails = 0;
    int accepts = 0;
    int exp_accepts = 0;

    logic [31:0] model [0:(1<<DEPTH_LOG2)-1];
    logic [31:0] exp_q [$];

    mainmem_responder #(
        .WORDS(WORDS), .LATENCY(LATENCY), .DEPTH_LOG2(DEPTH_LOG2)
    ) dut (
        .clk(clk), .reset(reset),
        .reqvalid(reqvalid), .reqready(reqready), .reqwrite(reqwrite), .reqaddr(reqaddr),
        .wvalid(wvalid), .wdata(wdata), .wready(wready),
        .rvalid(rvalid), .rdata(rdata), .rlast(rlast),
        .done(done), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (reset && reqvalid && reqready) accepts++;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout want finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    function automatic int widx(input logic [31:0] addr, input int k);
        int idx;
        idx = (int'(addr) >> 2) & ((1 << DEPTH_LOG2) - 1);
        return (idx & ~(WORDS - 1)) | (k % WORDS);
    endfunction

    // Issue a request from IDLE and wait for the first beat cycle.
    task automatic start_req(input bit wr, input logic [31:0] addr, input bit hold);
        int lat;
        check("reqready_idle", reqready, 1);
        reqvalid = 1'b1;
        reqwrite = wr;
        reqaddr  = addr;
        exp_accepts++;
        @(negedge clk);
        if (!hold) reqvalid = 1'b0;
        check("busy_after_accept", busy, 1);
        check("reqready_busy", reqready, 0);
        lat = 1;
        while (!(rvalid || wready) && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        check("first_beat_latency", lat, LATENCY + 1);
    endtask

    task automatic write_line(input logic [31:0] addr,
                              input logic [31:0] d0, input logic [31:0] d1,
                              input logic [31:0] d2, input logic [31:0] d3,
                              input int gap_at, input int gap_len);
        logic [31:0] d [4];
        d[0] = d0; d[1] = d1; d[2] = d2; d[3] = d3;
        start_req(1'b1, addr, 1'b0);
        for (int k = 0; k < WORDS; k++) begin
            if (k == gap_at) begin
                for (int g = 0; g < gap_len; g++) begin
                    wvalid = 1'b0;
                    check("wready_gap", wready, 1);
                    check("done_in_gap", done, 0);
                    @(negedge clk);
                end
            end
            check("wready_beat", wready, 1);
            wvalid = 1'b1;
            wdata  = d[k];
            model[widx(addr, k)] = d[k];
            @(negedge clk);
            if (k < WORDS - 1) check("done_early", done, 0);
        end
        wvalid = 1'b0;
        check("done_pulse", done, 1);
        check("wready_in_done", wready, 0);
        @(negedge clk);
        check("done_once", done, 0);
        check("reqready_after_done", reqready, 1);
    endtask

    task automatic read_line(input logic [31:0] addr, input bit hold);
        int o;
        logic [31:0] exp;
`ifdef MAINMEM_CWF_EN
        o = (int'(addr) >> 2) % WORDS;
`else
        o = 0;
`endif
        for (int k = 0; k < WORDS; k++) exp_q.push_back(model[widx(addr, (o + k) % WORDS)]);
        start_req(1'b0, addr, hold);
        for (int k = 0; k < WORDS; k++) begin
            check("rvalid_beat", rvalid, 1);
            if (exp_q.size() > 0) begin
                exp = exp_q.pop_front();
                check("rdata_beat", rdata, exp);
            end else begin
                check("scoreboard_empty", 32'd0, 32'd1);
            end
            check("rlast_beat", rlast, (k == WORDS - 1) ? 1 : 0);
            check("reqready_in_burst", reqready, 0);
            @(negedge clk);
        end
        check("rvalid_after_burst", rvalid, 0);
        check("rlast_after_burst", rlast, 0);
    endtask

    initial begin
        // Reset held for three cycles.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst_reqready", reqready, 0);
            check("rst_busy", busy, 0);
            check("rst_rvalid", rvalid, 0);
        end
        reset = 1'b1;
        #1;
        check("idle_reqready", reqready, 1);
        check("idle_busy", busy, 0);
        check("idle_rvalid", rvalid, 0);
        check("idle_wready", wready, 0);
        check("idle_done", done, 0);
        @(negedge clk);

        // Write a line, then read it back in the cycle after done.
        write_line(32'h40, 32'h11, 32'h22, 32'h33, 32'h44, -1, 0);
        read_line(32'h40, 1'b0);

        // Mid-line read: wraps when critical-word-first is built in.
        read_line(32'h48, 1'b0);

        // Write with a three-cycle gap between beats 1 and 2.
        write_line(32'hC0, 32'hA1, 32'hA2, 32'hA3, 32'hA4, 2, 3);
        read_line(32'hC0, 1'b0);

        // Stray write beats in IDLE must not touch storage.
        wvalid = 1'b1;
        wdata  = 32'hDEAD_BEEF;
        @(negedge clk);
        check("stray_wready", wready, 0);
        @(negedge clk);
        wvalid = 1'b0;

        // reqvalid held through a read burst: exactly one extra accept after.
        read_line(32'h40, 1'b1);
        read_line(32'hC0, 1'b0);

        // Reset in the middle of a write burst.
        write_line(32'h80, 32'hB0, 32'hB1, 32'hB2, 32'hB3, -1, 0);
        start_req(1'b1, 32'h80, 1'b0);
        wvalid = 1'b1;
        wdata  = 32'hC0C0_0000;
        model[widx(32'h80, 0)] = wdata;
        @(negedge clk);
        wdata  = 32'hC0C0_0001;
        model[widx(32'h80, 1)] = wdata;
        @(negedge clk);
        wvalid = 1'b0;
        reset  = 1'b0;
        #1;
        check("midrst_reqready", reqready, 0);
        check("midrst_busy", busy, 0);
        check("midrst_wready", wready, 0);
        check("midrst_rvalid", rvalid, 0);
        check("midrst_rdata", rdata, 0);
        check("midrst_done", done, 0);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("midrst_no_done", done, 0);
        end
        reset = 1'b1;
        #1;
        check("postrst_reqready", reqready, 1);
        @(negedge clk);
        read_line(32'h80, 1'b0);

        check("accept_count", accepts, exp_accepts);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
